// File: rtl/shared_acc_arbiter.sv
// Round-robin offload arbiter: N cores share one accelerator through a single
// registered request slot, with per-core credits and hart-id based response routing.

package shared_acc_arbiter_pkg;

  localparam int unsigned AddrWidth   = 3;
  localparam int unsigned IdWidth     = 5;
  localparam int unsigned DataWidth   = 32;
  localparam int unsigned HartIdWidth = 6;

  typedef struct packed {
    logic [AddrWidth-1:0] addr;
    logic [IdWidth-1:0]   id;
    logic [DataWidth-1:0] data_op;
    logic [DataWidth-1:0] data_arga;
    logic [DataWidth-1:0] data_argb;
    logic [DataWidth-1:0] data_argc;
  } acc_req_t;

  typedef struct packed {
    logic [HartIdWidth-1:0] hart_id;
    logic [AddrWidth-1:0]   addr;
    logic [IdWidth-1:0]     id;
    logic [DataWidth-1:0]   data_op;
    logic [DataWidth-1:0]   data_arga;
    logic [DataWidth-1:0]   data_argb;
    logic [DataWidth-1:0]   data_argc;
  } sh_acc_req_t;

  typedef struct packed {
    logic [IdWidth-1:0]   id;
    logic                 error;
    logic [DataWidth-1:0] data;
  } acc_resp_t;

  typedef struct packed {
    logic [IdWidth-1:0]     id;
    logic [HartIdWidth-1:0] hart_id;
    logic                   error;
    logic [DataWidth-1:0]   data;
  } sh_acc_resp_t;

endpackage

module shared_acc_arbiter
  import shared_acc_arbiter_pkg::*;
#(
  parameter int unsigned NrCores        = 4,
  parameter int unsigned MaxOutstanding = 2,
  parameter int unsigned CntWidth       = $clog2(MaxOutstanding + 1)
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  acc_req_t             core_req_i        [NrCores],
  input  logic [NrCores-1:0]   core_req_valid_i,
  output logic [NrCores-1:0]   core_req_ready_o,
  output acc_resp_t            core_resp_o       [NrCores],
  output logic [NrCores-1:0]   core_resp_valid_o,
  input  logic [NrCores-1:0]   core_resp_ready_i,
  output sh_acc_req_t          acc_req_o,
  output logic                 acc_req_valid_o,
  input  logic                 acc_req_ready_i,
  input  sh_acc_resp_t         acc_resp_i,
  input  logic                 acc_resp_valid_i,
  output logic                 acc_resp_ready_o,
  output logic                 resp_misroute_o
);

  localparam int unsigned IdxWidth = (NrCores > 1) ? $clog2(NrCores) : 1;
  localparam int unsigned SumWidth = IdxWidth + 1;

  localparam logic [CntWidth-1:0]  CntMax      = CntWidth'(MaxOutstanding);
  localparam logic [IdxWidth-1:0]  LastIdx     = IdxWidth'(NrCores - 1);
  localparam logic [SumWidth-1:0]  NrCoresSum  = SumWidth'(NrCores);
  localparam logic [HartIdWidth:0] NrCoresHart = (HartIdWidth + 1)'(NrCores);

  logic [NrCores-1:0]  eligible;
  logic [NrCores-1:0]  grant;
  logic                grant_any;
  logic [IdxWidth-1:0] grant_idx;
  logic [SumWidth-1:0] cand_sum;
  logic [IdxWidth-1:0] cand_idx;
  logic                can_load;
  logic                req_hs;

  logic [IdxWidth-1:0] rr_q, rr_d;
  sh_acc_req_t         req_q, req_d;
  logic                req_valid_q, req_valid_d;
  logic [CntWidth-1:0] cnt_q [NrCores];

  logic [NrCores-1:0]  resp_hs;
  logic                resp_in_range;
  logic                misroute_q;

  // A core may compete only while it still holds a credit.
  always_comb begin
    eligible = '0;
    for (int unsigned k = 0; k < NrCores; k++) begin
      eligible[k] = core_req_valid_i[k] && (cnt_q[k] < CntMax);
    end
  end

  // Round-robin search starting at rr_q, wrapping past the last core.
  always_comb begin
    grant_any = 1'b0;
    grant_idx = '0;
    cand_sum  = '0;
    cand_idx  = '0;
    for (int unsigned i = 0; i < NrCores; i++) begin
      cand_sum = SumWidth'(rr_q) + SumWidth'(i);
      if (cand_sum >= NrCoresSum) begin
        cand_sum = cand_sum - NrCoresSum;
      end
      cand_idx = cand_sum[IdxWidth-1:0];
      if (!grant_any && eligible[cand_idx]) begin
        grant_any = 1'b1;
        grant_idx = cand_idx;
      end
    end
  end

  assign can_load = !req_valid_q || acc_req_ready_i;
  assign req_hs   = grant_any && can_load;

  always_comb begin
    grant = '0;
    if (req_hs) begin
      grant[grant_idx] = 1'b1;
    end
  end

  assign core_req_ready_o = grant;

  always_comb begin
    rr_d = rr_q;
    if (req_hs) begin
      rr_d = (grant_idx == LastIdx) ? '0 : grant_idx + IdxWidth'(1);
    end
  end

  // Single-entry request slot; drains and reloads in the same cycle when ready.
  always_comb begin
    req_d       = req_q;
    req_valid_d = req_valid_q;
    if (acc_req_ready_i) begin
      req_valid_d = 1'b0;
    end
    if (req_hs) begin
      req_d = '{hart_id:   HartIdWidth'(grant_idx),
                addr:      core_req_i[grant_idx].addr,
                id:        core_req_i[grant_idx].id,
                data_op:   core_req_i[grant_idx].data_op,
                data_arga: core_req_i[grant_idx].data_arga,
                data_argb: core_req_i[grant_idx].data_argb,
                data_argc: core_req_i[grant_idx].data_argc};
      req_valid_d = 1'b1;
    end
  end

  assign acc_req_o       = req_q;
  assign acc_req_valid_o = req_valid_q;

  // Response demux: only the valid bit is steered, payload is broadcast.
  assign resp_in_range = {1'b0, acc_resp_i.hart_id} < NrCoresHart;

  always_comb begin
    core_resp_valid_o = '0;
    acc_resp_ready_o  = 1'b1;
    for (int unsigned k = 0; k < NrCores; k++) begin
      if (acc_resp_i.hart_id == HartIdWidth'(k)) begin
        core_resp_valid_o[k] = acc_resp_valid_i;
        acc_resp_ready_o     = core_resp_ready_i[k];
      end
    end
  end

  for (genvar k = 0; k < NrCores; k++) begin : g_resp
    assign core_resp_o[k] = '{id:    acc_resp_i.id,
                              error: acc_resp_i.error,
                              data:  acc_resp_i.data};
  end

  assign resp_hs         = core_resp_valid_o & core_resp_ready_i;
  assign resp_misroute_o = misroute_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rr_q        <= '0;
      req_q       <= '0;
      req_valid_q <= 1'b0;
      misroute_q  <= 1'b0;
    end else begin
      rr_q        <= rr_d;
      req_q       <= req_d;
      req_valid_q <= req_valid_d;
      misroute_q  <= acc_resp_valid_i && !resp_in_range;
    end
  end

  // Credit counters: request handshake takes a credit, response handshake returns it.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int unsigned k = 0; k < NrCores; k++) begin
        cnt_q[k] <= '0;
      end
    end else begin
      for (int unsigned k = 0; k < NrCores; k++) begin
        if (grant[k] && !resp_hs[k]) begin
          cnt_q[k] <= cnt_q[k] + CntWidth'(1);
        end else if (!grant[k] && resp_hs[k]) begin
          cnt_q[k] <= cnt_q[k] - CntWidth'(1);
        end
      end
    end
  end

  for (genvar k = 0; k < NrCores; k++) begin : g_credit_check
    a_no_underflow: assert property (@(posedge clk_i) disable iff (!rst_ni)
      (resp_hs[k] && !grant[k]) |-> (cnt_q[k] != '0));
  end

endmodule

// File: tb/tb_shared_acc_arbiter.sv
// Bench for shared_acc_arbiter: directed scenarios plus random traffic, all
// checked against a transaction-level model with a queue standing in for the unit.

module tb_shared_acc_arbiter;
  import shared_acc_arbiter_pkg::*;

  localparam int N      = 4;
  localparam int MaxOut = 2;

  logic         clk;
  logic         rst_n;
  acc_req_t     core_req [N];
  logic [N-1:0] core_req_valid, core_req_ready;
  acc_resp_t    core_resp [N];
  logic [N-1:0] core_resp_valid, core_resp_ready;
  sh_acc_req_t  acc_req;
  logic         acc_req_valid, acc_req_ready;
  sh_acc_resp_t acc_resp;
  logic         acc_resp_valid, acc_resp_ready;
  logic         misroute;

  shared_acc_arbiter #(.NrCores(N), .MaxOutstanding(MaxOut)) dut (
    .clk_i             (clk),
    .rst_ni            (rst_n),
    .core_req_i        (core_req),
    .core_req_valid_i  (core_req_valid),
    .core_req_ready_o  (core_req_ready),
    .core_resp_o       (core_resp),
    .core_resp_valid_o (core_resp_valid),
    .core_resp_ready_i (core_resp_ready),
    .acc_req_o         (acc_req),
    .acc_req_valid_o   (acc_req_valid),
    .acc_req_ready_i   (acc_req_ready),
    .acc_resp_i        (acc_resp),
    .acc_resp_valid_i  (acc_resp_valid),
    .acc_resp_ready_o  (acc_resp_ready),
    .resp_misroute_o   (misroute)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [191:0] got, input logic [191:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference model state
  int          m_rr;
  int          m_cnt [N];
  logic        m_req_valid;
  sh_acc_req_t m_req;
  logic        m_misroute;
  sh_acc_req_t unit_q [$];
  int          resp_sel;
  int          obs_grant [$];

  function automatic void model_reset();
    m_rr        = 0;
    m_req_valid = 1'b0;
    m_req       = '0;
    m_misroute  = 1'b0;
    for (int k = 0; k < N; k++) m_cnt[k] = 0;
    unit_q.delete();
  endfunction

  function automatic int model_grant();
    for (int i = 0; i < N; i++) begin
      int k;
      k = (m_rr + i) % N;
      if (core_req_valid[k] && m_cnt[k] < MaxOut) return k;
    end
    return -1;
  endfunction

  task automatic drive_idle();
    core_req_valid  = '0;
    core_resp_ready = '1;
    acc_req_ready   = 1'b1;
    acc_resp_valid  = 1'b0;
    acc_resp        = '0;
    resp_sel        = -1;
    for (int k = 0; k < N; k++) core_req[k] = '0;
  endtask

  task automatic drive_resp(input int idx, input logic [31:0] data, input logic err);
    acc_resp         = '0;
    acc_resp.id      = unit_q[idx].id;
    acc_resp.hart_id = unit_q[idx].hart_id;
    acc_resp.error   = err;
    acc_resp.data    = data;
    acc_resp_valid   = 1'b1;
    resp_sel         = idx;
  endtask

  task automatic auto_resp(input int skip);
    acc_resp_valid = 1'b0;
    resp_sel       = -1;
    foreach (unit_q[i]) begin
      if (resp_sel < 0 && int'(unit_q[i].hart_id) != skip) drive_resp(i, $urandom(), 1'b0);
    end
  endtask

  // Check all outputs mid-cycle against the model, then advance model and clock.
  task automatic cycle();
    int           g, h, gi;
    logic         can_load, in_range, exp_ar;
    logic [1:0]   hi;
    logic [N-1:0] exp_ready, exp_rv;
    acc_resp_t    exp_resp;
    #2;
    g         = model_grant();
    can_load  = !m_req_valid || acc_req_ready;
    exp_ready = '0;
    if (g >= 0 && can_load) exp_ready = N'(1) << g;
    check("core_req_ready", 192'(core_req_ready), 192'(exp_ready));
    check("acc_req_valid", 192'(acc_req_valid), 192'(m_req_valid));
    if (m_req_valid) check("acc_req_payload", 192'(acc_req), 192'(m_req));
    check("resp_misroute", 192'(misroute), 192'(m_misroute));
    h        = int'(acc_resp.hart_id);
    hi       = h[1:0];
    in_range = (h < N);
    exp_rv   = '0;
    if (in_range && acc_resp_valid) exp_rv = N'(1) << h;
    exp_ar   = in_range ? core_resp_ready[hi] : 1'b1;
    check("core_resp_valid", 192'(core_resp_valid), 192'(exp_rv));
    check("acc_resp_ready", 192'(acc_resp_ready), 192'(exp_ar));
    exp_resp = '{id: acc_resp.id, error: acc_resp.error, data: acc_resp.data};
    for (int k = 0; k < N; k++) check("core_resp_payload", 192'(core_resp[k]), 192'(exp_resp));
    gi = -1;
    for (int k = 0; k < N; k++) if (core_req_ready[k]) gi = k;
    obs_grant.push_back(gi);
    if (acc_resp_valid && in_range && core_resp_ready[hi]) begin
      m_cnt[h]--;
      if (resp_sel >= 0) unit_q.delete(resp_sel);
    end
    m_misroute = acc_resp_valid && !in_range;
    if (m_req_valid && acc_req_ready) begin
      unit_q.push_back(m_req);
      m_req_valid = 1'b0;
    end
    if (g >= 0 && can_load) begin
      m_req           = '0;
      m_req.hart_id   = 6'(g);
      m_req.addr      = core_req[g].addr;
      m_req.id        = core_req[g].id;
      m_req.data_op   = core_req[g].data_op;
      m_req.data_arga = core_req[g].data_arga;
      m_req.data_argb = core_req[g].data_argb;
      m_req.data_argc = core_req[g].data_argc;
      m_req_valid     = 1'b1;
      m_cnt[g]++;
      m_rr            = (g + 1) % N;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    for (int c = 0; c < 40 && (unit_q.size() != 0 || m_req_valid); c++) begin
      drive_idle();
      auto_resp(-1);
      cycle();
    end
    drive_idle();
    check("drain_pending", 192'(unit_q.size()), 192'(0));
    check("drain_idle", 192'(acc_req_valid), 192'(0));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int          start, cnt0, others, idx;
    sh_acc_req_t held;

    rst_n = 1'b0;
    drive_idle();
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check("rst_acc_req_valid", 192'(acc_req_valid), 192'(0));
    check("rst_acc_req", 192'(acc_req), 192'(0));
    check("rst_misroute", 192'(misroute), 192'(0));
    check("rst_resp_valid", 192'(core_resp_valid), 192'(0));
    acc_resp.hart_id = 6'd1;
    acc_resp_valid   = 1'b1;
    #1;
    check("rst_resp_passthru", 192'(core_resp_valid), 192'(4'b0010));
    acc_resp_valid = 1'b0;
    rst_n          = 1'b1;
    @(posedge clk);
    #1;

    // Single core request and response
    drive_idle();
    core_req[2].id      = 5'd5;
    core_req[2].data_op = 32'h0200_0053;
    core_req_valid[2]   = 1'b1;
    cycle();
    drive_idle();
    #1;
    check("t1_valid", 192'(acc_req_valid), 192'(1));
    check("t1_hart", 192'(acc_req.hart_id), 192'(2));
    check("t1_id", 192'(acc_req.id), 192'(5));
    cycle();
    drive_idle();
    drive_resp(0, 32'h3F80_0000, 1'b0);
    #1;
    check("t1_resp_valid", 192'(core_resp_valid), 192'(4'b0100));
    check("t1_resp_data", 192'(core_resp[2].data), 192'(32'h3F80_0000));
    cycle();

    // Fairness with all cores requesting and immediate responses
    drain();
    obs_grant.delete();
    start = m_rr;
    for (int c = 0; c < 12; c++) begin
      core_req_valid = '1;
      for (int k = 0; k < N; k++) core_req[k].id = 5'($urandom());
      auto_resp(-1);
      cycle();
    end
    for (int c = 0; c < 12; c++) check("fair_order", 192'(obs_grant[c]), 192'((start + c) % N));

    // Credit limit on core 0
    drain();
    obs_grant.delete();
    for (int c = 0; c < 8; c++) begin
      core_req_valid = '1;
      auto_resp(0);
      cycle();
    end
    cnt0   = 0;
    others = 0;
    foreach (obs_grant[i]) begin
      if (obs_grant[i] == 0) cnt0++;
      else if (obs_grant[i] > 0) others++;
    end
    check("credit_core0_grants", 192'(cnt0), 192'(2));
    check("credit_others_granted", 192'(others >= 4), 192'(1));
    for (int c = 0; c < 3; c++) begin
      drive_idle();
      core_req_valid = 4'b0001;
      auto_resp(0);
      #1;
      check("credit_stall", 192'(core_req_ready[0]), 192'(0));
      cycle();
    end
    drive_idle();
    core_req_valid = 4'b0001;
    idx = -1;
    foreach (unit_q[i]) if (idx < 0 && unit_q[i].hart_id == 6'd0) idx = i;
    if (idx >= 0) drive_resp(idx, 32'h1234_5678, 1'b0);
    cycle();
    drive_idle();
    core_req_valid = 4'b0001;
    #1;
    check("credit_resume", 192'(core_req_ready[0]), 192'(1));
    cycle();

    // Backpressure: held payload stays put, no grants until ready returns
    drain();
    core_req_valid[1]      = 1'b1;
    core_req[1].addr       = 3'd6;
    core_req[1].id         = 5'd17;
    core_req[1].data_op    = $urandom();
    core_req[1].data_arga  = $urandom();
    core_req[1].data_argb  = $urandom();
    core_req[1].data_argc  = $urandom();
    acc_req_ready          = 1'b0;
    cycle();
    held = m_req;
    for (int c = 0; c < 5; c++) begin
      drive_idle();
      acc_req_ready  = 1'b0;
      core_req_valid = 4'b1100;
      #1;
      check("bp_payload", 192'(acc_req), 192'(held));
      check("bp_no_grant", 192'(core_req_ready), 192'(0));
      cycle();
    end
    drive_idle();
    core_req_valid = 4'b1100;
    #1;
    check("bp_drain_load", 192'(core_req_ready != '0), 192'(1));
    cycle();
    check("bp_reload", 192'(acc_req_valid), 192'(1));

    // Misrouted response is sunk and flagged one cycle later
    drain();
    acc_resp.hart_id = 6'd9;
    acc_resp.id      = 5'd3;
    acc_resp.data    = 32'hDEAD_BEEF;
    acc_resp_valid   = 1'b1;
    core_resp_ready  = '0;
    #1;
    check("mis_ready", 192'(acc_resp_ready), 192'(1));
    check("mis_no_valid", 192'(core_resp_valid), 192'(0));
    cycle();
    drive_idle();
    #1;
    check("mis_pulse", 192'(misroute), 192'(1));
    cycle();
    drive_idle();
    core_req_valid = 4'b0001;
    #1;
    check("mis_pulse_end", 192'(misroute), 192'(0));
    cycle();
    cycle();

    // Reset in flight with core 1 at its credit limit
    drain();
    core_req_valid[1] = 1'b1;
    cycle();
    cycle();
    drive_idle();
    acc_req_ready     = 1'b0;
    core_req_valid[1] = 1'b1;
    #1;
    check("rf_stall", 192'(core_req_ready[1]), 192'(0));
    #1;
    rst_n = 1'b0;
    #1;
    check("rf_valid", 192'(acc_req_valid), 192'(0));
    model_reset();
    @(posedge clk);
    #2;
    rst_n = 1'b1;
    #1;
    check("rf_regrant", 192'(core_req_ready[1]), 192'(1));
    @(posedge clk);
    #1;
    m_req_valid     = 1'b1;
    m_req           = '0;
    m_req.hart_id   = 6'd1;
    m_cnt[1]        = 1;
    m_rr            = 2;
    drive_idle();
    cycle();

    // Random traffic
    drain();
    for (int c = 0; c < 400; c++) begin
      int r;
      core_req_valid = N'($urandom());
      for (int k = 0; k < N; k++) begin
        core_req[k].addr      = 3'($urandom());
        core_req[k].id        = 5'($urandom());
        core_req[k].data_op   = $urandom();
        core_req[k].data_arga = $urandom();
        core_req[k].data_argb = $urandom();
        core_req[k].data_argc = $urandom();
      end
      acc_req_ready    = ($urandom_range(0, 9) < 7);
      core_resp_ready  = N'($urandom());
      acc_resp_valid   = 1'b0;
      resp_sel         = -1;
      acc_resp.id      = 5'($urandom());
      acc_resp.hart_id = 6'($urandom());
      acc_resp.error   = 1'($urandom());
      acc_resp.data    = $urandom();
      r = int'($urandom_range(0, 19));
      if (r == 0) begin
        acc_resp.hart_id = 6'($urandom_range(4, 63));
        acc_resp_valid   = 1'b1;
      end else if (r < 12 && unit_q.size() > 0) begin
        drive_resp(int'($urandom_range(0, unit_q.size() - 1)), $urandom(), 1'($urandom()));
      end
      cycle();
    end
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/shared_acc_arbiter.md
# shared_acc_arbiter

Tile-level offload arbiter that lets `NrCores` Snitch cores share one accelerator (e.g. the tile-shared FP div/sqrt unit). It round-robins accelerator requests from the cores onto a single registered request port, tagging each request with the issuing core's hart id. It routes tagged responses back to the originating core. Per-core credit counters bound outstanding requests, so one core cannot flood the shared unit.

## Interface
Parameters:
- `NrCores`, 4: number of requesting cores; range 2..64.
- `MaxOutstanding`, 2: maximum in-flight requests per core; at least 1.
- `CntWidth`, `$clog2(MaxOutstanding+1)`: credit counter width; derived, do not override.

Ports:
- `clk_i`  in  1  clock
- `rst_ni`  in  1  asynchronous active-low reset
- `core_req_i`  in  `[NrCores]` acc_req_t  per-core request: addr 3b, id 5b, data_op 32b, data_arga/b/c 32b each
- `core_req_valid_i`  in  `[NrCores]`  request valid
- `core_req_ready_o`  out  `[NrCores]`  request accepted
- `core_resp_o`  out  `[NrCores]` acc_resp_t  response: id 5b, error 1b, data 32b
- `core_resp_valid_o`  out  `[NrCores]`  response valid
- `core_resp_ready_i`  in  `[NrCores]`  response ready
- `acc_req_o`  out  sh_acc_req_t  request to shared unit; hart_id 6b = core index
- `acc_req_valid_o`  out  1  request valid (registered)
- `acc_req_ready_i`  in  1  shared unit ready
- `acc_resp_i`  in  sh_acc_resp_t  response from shared unit: id, hart_id, error, data
- `acc_resp_valid_i`  in  1  response valid
- `acc_resp_ready_o`  out  1  response ready
- `resp_misroute_o`  out  1  one-cycle pulse: response hart_id >= NrCores was dropped

## Operation
- Eligibility: core k is eligible when `core_req_valid_i[k]` is high and `cnt[k] < MaxOutstanding`.
- Arbitration is round-robin. Pointer `rr_q` is the highest-priority core. Search starts at `rr_q` and proceeds in increasing index with wrap. The first eligible core wins.
- On each grant to core k, `rr_q <= (k+1) mod NrCores`. With no grant, `rr_q` holds.
- Request register is a single entry (`req_q`, `req_valid_q`).
  - It can load when `!req_valid_q` or when `acc_req_ready_i` is high (drain and load in the same cycle).
  - `core_req_ready_o[k] = grant[k] & can_load`. At most one bit is high per cycle.
- On a core handshake, `req_q` captures all fields of `core_req_i[k]` and sets `hart_id = k` (zero-extended to 6b).
- `acc_req_o = req_q`, `acc_req_valid_o = req_valid_q`. The payload is stable while valid and not ready.
- Response routing:
  - When `acc_resp_i.hart_id < NrCores`, drive `core_resp_valid_o[hart_id] = acc_resp_valid_i` and `acc_resp_ready_o = core_resp_ready_i[hart_id]`.
  - `core_resp_o[k]` carries id, error and data from `acc_resp_i` for every k; only the valid bit is demuxed.
- Misroute: when `acc_resp_i.hart_id >= NrCores`, `acc_resp_ready_o = 1` (sink) and no core valid is asserted. `resp_misroute_o` pulses for one cycle on that handshake.
- Credits:
  - `cnt[k]` increments on a core-k request handshake.
  - `cnt[k]` decrements on a core-k response handshake.
  - Both in the same cycle leave it unchanged.
  - A decrement at 0 is illegal and must be flagged by an assertion. An increment past MaxOutstanding cannot occur by construction.
- The response path is independent of the request path; both may handshake in the same cycle.

## Timing
- Reset values: `req_valid_q=0`, `req_q=0`, `rr_q=0`, all `cnt=0`, `resp_misroute_o=0`.
- Outputs during reset: `acc_req_valid_o=0` and all `core_resp_valid_o=0` unless `acc_resp_valid_i` is high.
- Request latency: a core handshake in cycle t gives `acc_req_valid_o` high in cycle t+1. Full throughput is 1 request/cycle while `acc_req_ready_i` is held high.
- Response latency: zero cycles, purely combinational from `acc_resp_*` to `core_resp_*`.
- `resp_misroute_o` is registered: a handshake in cycle t gives a pulse in cycle t+1.
- An asynchronous reset mid-operation discards the held request and all credits. Responses for pre-reset requests are not expected; the shared unit is reset together with this block.

## Test plan
- Single core: core 2 issues id=5, data_op=0x0200_0053 -> `acc_req_valid_o` high next cycle with hart_id=2 and id=5. Response hart_id=2, data=0x3F80_0000 -> `core_resp_valid_o=4'b0100` with data 0x3F80_0000.
- Fairness: all 4 cores valid continuously with `acc_req_ready_i=1` and responses returned immediately -> grants in order 0,1,2,3,0,1,… with exactly one grant per cycle.
- Credit limit, MaxOutstanding=2: core 0 issues 3 back-to-back requests with no responses -> 2 accepted, third stalls (`ready=0`) while cores 1–3 are still granted. One response to core 0 -> third is accepted on the following cycle.
- Backpressure: `acc_req_ready_i=0` for 5 cycles with a request held -> payload unchanged, no further core grants. Ready rises -> drain and new load in the same cycle.
- Misroute: NrCores=4, response hart_id=9 -> `acc_resp_ready_o=1`, no core valid, `resp_misroute_o` pulses one cycle later, counters unchanged.
- Reset mid-flight: `rst_ni` low while `req_valid_q=1` and `cnt[1]=2` -> `acc_req_valid_o=0` and counters 0 immediately. After release, core 1 is granted immediately.
